// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns and extends memory accesses onto a simple req/ack word bus.
// Optional LSU_TIMEOUT_EN adds an 8-bit REQ watchdog that aborts a stuck access with Fault.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemValid,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBe,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [2:0]  r_funct3;

  logic        w_legal;
  logic        w_accept;
  logic        w_to_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  r_to_cnt;
  logic        r_to_fault;
  assign w_to_fault = r_to_fault;
`else
  assign w_to_fault = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default up front, so no path can infer a latch.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    case (Funct3)
      3'b000: begin w_legal = 1'b1;                       w_be = 4'b0001 << ALUResult[1:0]; end
      3'b100: begin w_legal = !MemWrite;                  w_be = 4'b0001 << ALUResult[1:0]; end
      3'b001: begin w_legal = !ALUResult[0];              w_be = ALUResult[1] ? 4'b1100 : 4'b0011; end
      3'b101: begin w_legal = !MemWrite && !ALUResult[0]; w_be = ALUResult[1] ? 4'b1100 : 4'b0011; end
      3'b010: begin w_legal = (ALUResult[1:0] == 2'b00);  w_be = 4'b1111; end
      default: ;
    endcase
  end

  // Store data is replicated so the addressed lane always carries it, whatever the offset.
  always_comb begin
    w_wdata = 32'h0;
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00:   w_wdata = {4{WriteData[7:0]}};
        2'b01:   w_wdata = {2{WriteData[15:0]}};
        default: w_wdata = WriteData;
      endcase
    end
  end

  assign w_shifted = BusRData >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = 32'h0;
    if (!r_we) begin
      case (r_funct3)
        3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
        3'b100:  w_load = {24'h0, w_shifted[7:0]};
        3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
        3'b101:  w_load = {16'h0, w_shifted[15:0]};
        3'b010:  w_load = BusRData;
        default: w_load = 32'h0;
      endcase
    end
  end

  // Reset gates the combinational IDLE outputs so every output reads 0 while rst_n is low.
  assign w_accept = rst_n && (r_state == IDLE) && MemValid && w_legal && !w_to_fault;

  assign Stall    = w_accept || (r_state == REQ);
  assign Done     = (r_state == RESP);
  assign Fault    = (rst_n && (r_state == IDLE) && MemValid && !w_legal) || w_to_fault;
  assign ReadData = r_rdata;
  assign BusReq   = (r_state == REQ);
  assign BusWe    = BusReq && r_we;
  assign BusAddr  = BusReq ? {r_addr[31:2], 2'b00} : 32'h0;
  assign BusWData = BusReq ? r_wdata : 32'h0;
  assign BusBe    = BusReq ? r_be : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_be     <= 4'b0000;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
`ifdef LSU_TIMEOUT_EN
      r_to_cnt   <= 8'h0;
      r_to_fault <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      r_to_fault <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= ALUResult;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_we     <= MemWrite;
            r_funct3 <= Funct3;
            r_state  <= REQ;
`ifdef LSU_TIMEOUT_EN
            r_to_cnt <= 8'h0;
`endif
          end
        end
        REQ: begin
          if (BusAck) begin
            r_rdata <= w_load;
            r_state <= RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_to_cnt == 8'hFF) begin
            r_to_fault <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'h1;
          end
`endif
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed accesses plus reset/ack corner sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemValid, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, Done, Fault;
  logic [31:0] ReadData;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusBe;
  logic        BusAck;
  logic [31:0] BusRData;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .MemValid(MemValid), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .Stall(Stall), .Done(Done), .ReadData(ReadData), .Fault(Fault),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusBe(BusBe), .BusAck(BusAck), .BusRData(BusRData)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // REQ cycles, BusAck in the last one
    logic        fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cnt;
    logic stable;
    @(negedge clk);
    MemValid = 1'b1; MemWrite = v.we; Funct3 = v.f3; ALUResult = v.addr; WriteData = v.wdata;
    #1;
    if (v.fault) begin
      check({v.name, " fault"}, Fault, 1);
      check({v.name, " stall"}, Stall, 0);
      check({v.name, " busreq"}, BusReq, 0);
      @(posedge clk); #1;
      check({v.name, " busreq after edge"}, BusReq, 0);
      MemValid = 1'b0;
      return;
    end
    check({v.name, " no fault"}, Fault, 0);
    stall_cnt = Stall;
    @(negedge clk);
    MemValid = 1'b0;
    check({v.name, " busreq"}, BusReq, 1);
    check({v.name, " busaddr"}, BusAddr, v.exp_addr);
    check({v.name, " busbe"}, {28'h0, BusBe}, {28'h0, v.exp_be});
    check({v.name, " buswdata"}, BusWData, v.exp_wdata);
    check({v.name, " buswe"}, {31'h0, BusWe}, {31'h0, v.we});
    stable = 1'b1;
    for (int i = 1; i <= v.delay; i++) begin
      stall_cnt += Stall;
      if (BusReq !== 1'b1 || BusAddr !== v.exp_addr || BusBe !== v.exp_be ||
          BusWData !== v.exp_wdata || BusWe !== v.we || Done !== 1'b0)
        stable = 1'b0;
      if (i == v.delay) begin
        BusAck = 1'b1; BusRData = v.rdata;
      end
      @(negedge clk);
    end
    BusAck = 1'b0; BusRData = 32'h5A5A_5A5A;
    check({v.name, " bus stable"}, {31'h0, stable}, 1);
    check({v.name, " stall cycles"}, stall_cnt, v.delay + 1);
    check({v.name, " done"}, Done, 1);
    check({v.name, " readdata"}, ReadData, v.exp_rdata);
    check({v.name, " resp stall"}, Stall, 0);
    check({v.name, " resp busreq"}, BusReq, 0);
    @(negedge clk);
    check({v.name, " done one cycle"}, Done, 0);
    check({v.name, " readdata hold"}, ReadData, v.exp_rdata);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"LB 0x103",  1'b0, 3'b000, 32'h103, 32'h0,         32'h80AA_BBCC, 1, 1'b0, 32'h100, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{"SH 0x202",  1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 1'b0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{"LW 0x301",  1'b0, 3'b010, 32'h301, 32'h0,         32'h0,         0, 1'b1, 32'h0,   4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{"F3 011",    1'b0, 3'b011, 32'h300, 32'h0,         32'h0,         0, 1'b1, 32'h0,   4'b0000, 32'h0,         32'h0};
    vecs[4]  = '{"LHU 0x40",  1'b0, 3'b101, 32'h40,  32'h0,         32'h0000_9001, 5, 1'b0, 32'h40,  4'b0011, 32'h0,         32'h0000_9001};
    vecs[5]  = '{"LH 0x42",   1'b0, 3'b001, 32'h42,  32'h0,         32'h8001_0000, 1, 1'b0, 32'h40,  4'b1100, 32'h0,         32'hFFFF_8001};
    vecs[6]  = '{"LBU 0x101", 1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_F500, 2, 1'b0, 32'h100, 4'b0010, 32'h0,         32'h0000_00F5};
    vecs[7]  = '{"SB 0x3",    1'b1, 3'b000, 32'h3,   32'h0000_00A5, 32'h1111_1111, 1, 1'b0, 32'h0,   4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{"SW 0x10",   1'b1, 3'b010, 32'h10,  32'hCAFE_F00D, 32'h0,         3, 1'b0, 32'h10,  4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{"LW 0x8",    1'b0, 3'b010, 32'h8,   32'hFFFF_FFFF, 32'h1234_5678, 2, 1'b0, 32'h8,   4'b1111, 32'h0,         32'h1234_5678};
    vecs[10] = '{"LH 0x41",   1'b0, 3'b001, 32'h41,  32'h0,         32'h0,         0, 1'b1, 32'h0,   4'b0000, 32'h0,         32'h0};
    vecs[11] = '{"SBU store", 1'b1, 3'b100, 32'h4,   32'h0,         32'h0,         0, 1'b1, 32'h0,   4'b0000, 32'h0,         32'h0};
    vecs[12] = '{"SW 0x12",   1'b1, 3'b010, 32'h12,  32'h0,         32'h0,         0, 1'b1, 32'h0,   4'b0000, 32'h0,         32'h0};

    // Reset state, with an illegal request pending to show outputs stay quiet.
    rst_n = 1'b0; MemValid = 1'b1; MemWrite = 1'b0; Funct3 = 3'b011;
    ALUResult = 32'h0; WriteData = 32'h0; BusAck = 1'b0; BusRData = 32'h0;
    repeat (2) @(negedge clk);
    check("reset stall", Stall, 0);
    check("reset fault", Fault, 0);
    check("reset done", Done, 0);
    check("reset busreq", BusReq, 0);
    check("reset readdata", ReadData, 0);
    MemValid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // BusAck while idle must not start or complete anything.
    @(negedge clk);
    BusAck = 1'b1; BusRData = 32'hFFFF_FFFF;
    @(negedge clk);
    BusAck = 1'b0;
    check("stray ack done", Done, 0);
    check("stray ack busreq", BusReq, 0);
    check("stray ack readdata", ReadData, 32'h1234_5678);

    // Reset mid-REQ drops the bus request immediately and clears ReadData.
    @(negedge clk);
    MemValid = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h20;
    @(negedge clk);
    MemValid = 1'b0;
    check("pre-reset busreq", BusReq, 1);
    rst_n = 1'b0;
    #1;
    check("mid-req reset busreq", BusReq, 0);
    check("mid-req reset stall", Stall, 0);
    check("mid-req reset readdata", ReadData, 0);

    // First request after release is accepted on the very next edge.
    @(negedge clk);
    rst_n = 1'b1;
    MemValid = 1'b1; Funct3 = 3'b010; ALUResult = 32'h24;
    @(negedge clk);
    MemValid = 1'b0;
    check("post-reset accept busreq", BusReq, 1);
    check("post-reset busaddr", BusAddr, 32'h24);
    BusAck = 1'b1; BusRData = 32'h0BAD_F00D;
    @(negedge clk);
    BusAck = 1'b0;
    check("post-reset done", Done, 1);
    check("post-reset readdata", ReadData, 32'h0BAD_F00D);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
